// File: rtl/wr_capture_fifo.sv
// Serial-to-parallel word assembler feeding a DEPTH-entry FIFO (LSB first).
// Ports: i_clk, i_rst (sync, active-high), i_data/i_data_vld serial input,
// i_flush clear, o_word/o_word_vld/i_word_rdy read side, o_count, o_state,
// o_overflow. Macro WR_CAPTURE_PARITY_EN adds o_parity (per-entry XOR).
module wr_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_data,
  input  logic                     i_data_vld,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_word,
  output logic                     o_word_vld,
  input  logic                     i_word_rdy,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [1:0]               o_state,
  output logic                     o_overflow
`ifdef WR_CAPTURE_PARITY_EN
  ,
  output logic                     o_parity
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(WIDTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    STALL = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic              ovf_q, ovf_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              push, pop, room;
  logic [WIDTH-1:0]  push_data;
`ifdef WR_CAPTURE_PARITY_EN
  logic              par_q [DEPTH];
`endif

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    ovf_d     = ovf_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    push      = 1'b0;
    push_data = '0;
    pop       = (count_q != '0) && i_word_rdy;
    // A pop frees a slot on the same edge, so a full FIFO still accepts.
    room      = (count_q != FULL) || pop;

    unique case (state_q)
      IDLE, SHIFT: begin
        if (i_data_vld) begin
          shift_d[bitcnt_q] = i_data;
          if (bitcnt_q == LAST) begin
            bitcnt_d = '0;
            if (room) begin
              push      = 1'b1;
              push_data = shift_d;
              state_d   = IDLE;
            end else begin
              hold_d  = shift_d;
              state_d = STALL;
            end
            shift_d = '0;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
            state_d  = SHIFT;
          end
        end
      end
      STALL: begin
        if (i_data_vld) ovf_d = 1'b1;
        if (room) begin
          push      = 1'b1;
          push_data = hold_q;
          hold_d    = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    if (i_flush) begin
      state_d  = IDLE;
      bitcnt_d = '0;
      shift_d  = '0;
      hold_d   = '0;
      ovf_d    = 1'b0;
      wptr_d   = '0;
      rptr_d   = '0;
      count_d  = '0;
      push     = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      hold_q   <= '0;
      ovf_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      hold_q   <= hold_d;
      ovf_q    <= ovf_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are masked by occupancy.
  always_ff @(posedge i_clk) begin
    if (!i_rst && push) begin
      mem_q[wptr_q] <= push_data;
`ifdef WR_CAPTURE_PARITY_EN
      par_q[wptr_q] <= ^push_data;
`endif
    end
  end

  assign o_word_vld = (count_q != '0);
  assign o_word     = o_word_vld ? mem_q[rptr_q] : '0;
  assign o_count    = count_q;
  assign o_state    = state_q;
  assign o_overflow = ovf_q;
`ifdef WR_CAPTURE_PARITY_EN
  assign o_parity   = o_word_vld ? par_q[rptr_q] : 1'b0;
`endif

endmodule

// File: doc/wr_capture_fifo.md
WR_CAPTURE_FIFO -- requirements
Module: wr_capture_fifo

Interface
REQ-001 Parameter WIDTH, default 8: bits per assembled word; legal range 2..32.
REQ-002 Parameter DEPTH, default 4: FIFO entries; power of two, 2..16.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  input  1  synchronous reset, active-high, sampled on rising edge of i_clk.
REQ-005 i_data  input  1  serial data bit, LSB of word first.
REQ-006 i_data_vld  input  1  i_data valid this cycle.
REQ-007 i_flush  input  1  synchronous clear of all datapath state.
REQ-008 o_word  output  WIDTH  head-of-FIFO word.
REQ-009 o_word_vld  output  1  FIFO non-empty.
REQ-010 i_word_rdy  input  1  downstream accepts o_word this cycle.
REQ-011 o_count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-012 o_state  output  2  assembler state: IDLE=2'b00, SHIFT=2'b01, STALL=2'b11.
REQ-013 o_overflow  output  1  sticky flag, bit lost.

Function
REQ-014 Assembler SHALL shift i_data into bit position bitcnt on each cycle with i_data_vld=1 in IDLE or SHIFT; bitcnt increments 0..WIDTH-1.
REQ-015 IDLE->SHIFT on first accepted bit; SHIFT stays SHIFT while bitcnt<WIDTH-1 after the bit.
REQ-016 On accepting bit WIDTH-1: if FIFO has room (count<DEPTH, or pop this same cycle), word pushed same edge, bitcnt->0, state->IDLE.
REQ-017 On accepting bit WIDTH-1 with FIFO full and no pop that cycle: word held in holding register, state->STALL.
REQ-018 In STALL, held word pushed on the first cycle a slot is free (count<DEPTH or pop); state->IDLE same edge.
REQ-019 In STALL, any i_data_vld=1 SHALL drop that bit and set o_overflow=1 on the next edge.
REQ-020 Pop occurs when o_word_vld=1 and i_word_rdy=1; o_word advances to next entry next cycle.
REQ-021 Simultaneous push and pop SHALL leave o_count unchanged; push when full SHALL be accepted only if pop same cycle.
REQ-022 i_word_rdy while o_word_vld=0 SHALL have no effect; o_count never underflows or exceeds DEPTH.
REQ-023 Latency: last bit sampled at edge N into empty FIFO -> o_word_vld=1 and o_word valid after edge N (visible cycle N+1).
REQ-024 Read/write pointers SHALL wrap modulo DEPTH without gaps; FIFO order strictly first-in first-out.
REQ-025 o_word SHALL be 0 when o_word_vld=0.
REQ-026 i_flush=1 SHALL, on that edge, empty FIFO, clear bitcnt, shift and holding registers, clear o_overflow, state->IDLE; flush overrides simultaneous push/pop/data.

Reset
REQ-027 i_rst=1 SHALL produce same state as i_flush; after the edge: o_word=0, o_word_vld=0, o_count=0, o_state=IDLE, o_overflow=0.
REQ-028 i_rst SHALL override i_flush and all inputs; reset mid-word or mid-STALL discards partial/held word.
REQ-029 No output SHALL change asynchronously to i_rst.

Configuration
REQ-030 Macro WR_CAPTURE_PARITY_EN defined: extra output o_parity (1 bit) = XOR of all bits of stored word, computed at push, stored per entry, presented with o_word; 0 when o_word_vld=0.
REQ-031 Macro undefined: o_parity port and per-entry parity storage SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset, then 8 valid bits 1,0,1,0,0,1,0,1 (LSB first), i_word_rdy=0 -> next cycle o_word=8'hA5, o_word_vld=1, o_count=1, o_state=IDLE.
REQ-033 i_word_rdy=0, 5 words 8'h01..8'h05 streamed -> o_count=4, o_state=STALL; 9th bit valid -> o_overflow=1; assert i_word_rdy -> outputs 01,02,03,04,05 in order.
REQ-034 FIFO full (count=4), last bit of new word arrives with i_word_rdy=1 same cycle -> push accepted, o_count stays 4, o_state=IDLE, o_overflow=0.
REQ-035 Flush asserted mid-word (bitcnt=3) with count=2, overflow set -> next cycle o_count=0, o_word_vld=0, o_overflow=0; next 8 bits form a clean word.
REQ-036 i_rst asserted in STALL with simultaneous i_flush and i_data_vld -> all outputs at reset values; with WR_CAPTURE_PARITY_EN, word 8'h07 -> o_parity=1, word 8'h03 -> o_parity=0.
